avl_axi_stream_fifo: RTL and testbench
======================================

Name: avl_axi_stream_fifo

Overview:
Parametrised AXI-Stream buffer between one slave (s_) and one master (m_) port.
- Carries the full AXI-Stream signal set (tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup), each sized by parameter.
- Adds configurable depth, an optional store-and-forward packet mode, a fill-level output, and overflow detection for slaves built without tready.
- Sits at AXI-Stream boundaries in the AVL testbench infrastructure for elasticity, rate matching and packet framing.

Parameters:
VERSION, 4, AXI-Stream protocol version; twakeup is active only when VERSION >= 5.
TDATA_WIDTH, 32, data width in bits; multiple of 8 and > 0, otherwise $fatal at elaboration.
TID_WIDTH, 0, tid width; 0 means absent (1-bit port, input ignored, output driven 0).
TDEST_WIDTH, 0, tdest width; 0 means absent (same rule as TID_WIDTH).
TUSER_WIDTH, 0, tuser width; 0 means absent (same rule as TID_WIDTH).
DEPTH, 16, number of entries; power of two and >= 2, otherwise $fatal.
PACKET_MODE, 0, 1 enables store-and-forward release on tlast.
Tready_Signal, 1, 0 means the upstream ignores s_tready; overflow detection is then enabled.

Ports:
aclk  in  1  clock; all logic on the rising edge.
areset  in  1  asynchronous reset, active-high.
s_tvalid  in  1  slave beat valid.
s_tready  out  1  slave ready.
s_tdata  in  TDATA_WIDTH  slave data.
s_tstrb  in  TDATA_WIDTH/8  slave byte strobes.
s_tkeep  in  TDATA_WIDTH/8  slave byte keeps.
s_tlast  in  1  slave end of packet.
s_tid  in  max(TID_WIDTH,1)  slave stream id.
s_tdest  in  max(TDEST_WIDTH,1)  slave routing destination.
s_tuser  in  max(TUSER_WIDTH,1)  slave user sideband.
s_twakeup  in  1  slave wakeup.
m_tvalid  out  1  master beat valid.
m_tready  in  1  master ready.
m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser  out  same widths as the s_ counterparts  master beat fields.
m_twakeup  out  1  master wakeup.
level  out  $clog2(DEPTH)+1  current entry count, range 0..DEPTH.
overflow  out  1  sticky flag: a beat was dropped.

Behaviour:
- Reset values (asserted asynchronously): level=0, m_tvalid=0, s_tready=0, overflow=0, m_twakeup=0. All m_ payload outputs are 0. Pointers and packet counter are 0. Storage contents are not reset.
- After reset deasserts, s_tready rises on the first aclk edge.
- Push: s_tvalid && s_tready at an edge writes one entry.
- Pop: m_tvalid && m_tready at an edge advances the read pointer.
- Pointers are $clog2(DEPTH)+1 bits wide, with the extra bit used for wrap detection.
  - empty: pointers equal.
  - full: indices equal and MSBs differ.
- s_tready is registered and equals (level_next < DEPTH). It does not depend on m_tready combinationally. When full, a same-cycle pop does not allow a same-cycle push.
- Latency: a beat pushed at edge N is presented on m_ at edge N+1 at the earliest. Output payload is registered and shows the head entry.
- m_ payload and m_tvalid stay stable while m_tvalid && !m_tready.
- Simultaneous push and pop with 0 < level < DEPTH leaves level unchanged.
- PACKET_MODE=0: m_tvalid = !empty.
- PACKET_MODE=1:
  - pkt_cnt (width $clog2(DEPTH)+1) increments on a push with s_tlast and decrements on a pop with m_tlast. A simultaneous increment and decrement holds the count.
  - m_tvalid = !empty && (pkt_cnt > 0 || full). The full term is a forced release to prevent deadlock on packets longer than DEPTH.
  - Once forced release begins, beats flow cut-through until that packet's tlast pops.
- Tready_Signal=0:
  - A push attempted when full (s_tvalid && level==DEPTH) drops the beat and sets overflow. overflow stays set until reset.
  - s_tready is still driven for observation.
- Tready_Signal=1: overflow stays 0.
- m_twakeup = (VERSION >= 5) ? registered(s_twakeup || !empty) : 0.
- Sideband width 0: the input is ignored, nothing is stored for it, and the output is tied to 0.
- Reset mid-packet: all entries are discarded, pkt_cnt clears, and no partial packet emerges afterwards.

Test Plan:
- DEPTH=4, PACKET_MODE=0: push 0xA0..0xA3 with m_tready=0 -> level=4 and s_tready=0. Raise m_tready -> m_tdata reads A0, A1, A2, A3 on consecutive cycles, then m_tvalid=0 and level=0.
- Continuous push and pop with m_tready=1 -> after a 1-cycle fill latency, 1 beat/cycle throughput, level stays at 1, wrap-around passes 3×DEPTH beats in order.
- PACKET_MODE=1, DEPTH=8: push a 3-beat packet with tlast on beat 3 -> m_tvalid stays 0 until the edge after beat 3 is pushed, then 3 beats out, m_tlast on the 3rd.
- PACKET_MODE=1, DEPTH=4: push a 6-beat packet -> forced release at level=4, all 6 beats delivered in order, pkt_cnt returns to 0.
- Tready_Signal=0, DEPTH=2, m_tready=0: push 3 beats -> the 3rd beat is dropped, overflow=1 and stays set, the first 2 beats are delivered intact.
- Assert areset with level=3 mid-packet -> level=0, m_tvalid=0 and s_tready=0 immediately. After release, a new 1-beat packet emerges alone with correct tid, tdest and tuser (TID_WIDTH=4, tid=0x5).

Source files
------------

// File: rtl/avl_axi_stream_fifo.sv
// AXI-Stream buffer with configurable depth, optional store-and-forward
// packet release, fill level, and drop detection for sources without tready.
// m_ outputs are registered from the next head, so a beat written at one
// edge is visible right after it and can be taken at the following edge.
module avl_axi_stream_fifo #(
    parameter int VERSION       = 4,
    parameter int TDATA_WIDTH   = 32,
    parameter int TID_WIDTH     = 0,
    parameter int TDEST_WIDTH   = 0,
    parameter int TUSER_WIDTH   = 0,
    parameter int DEPTH         = 16,
    parameter int PACKET_MODE   = 0,
    parameter int Tready_Signal = 1,
    localparam int SW = (TDATA_WIDTH / 8 > 0) ? TDATA_WIDTH / 8 : 1,
    localparam int IW = (TID_WIDTH > 0) ? TID_WIDTH : 1,
    localparam int DW = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1,
    localparam int UW = (TUSER_WIDTH > 0) ? TUSER_WIDTH : 1,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int PW = AW + 1
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [TDATA_WIDTH-1:0] s_tdata,
    input  logic [SW-1:0]          s_tstrb,
    input  logic [SW-1:0]          s_tkeep,
    input  logic                   s_tlast,
    input  logic [IW-1:0]          s_tid,
    input  logic [DW-1:0]          s_tdest,
    input  logic [UW-1:0]          s_tuser,
    input  logic                   s_twakeup,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [TDATA_WIDTH-1:0] m_tdata,
    output logic [SW-1:0]          m_tstrb,
    output logic [SW-1:0]          m_tkeep,
    output logic                   m_tlast,
    output logic [IW-1:0]          m_tid,
    output logic [DW-1:0]          m_tdest,
    output logic [UW-1:0]          m_tuser,
    output logic                   m_twakeup,
    output logic [PW-1:0]          level,
    output logic                   overflow
);

    localparam int CW = TDATA_WIDTH + 2 * SW + 1;

    if (TDATA_WIDTH <= 0 || (TDATA_WIDTH % 8) != 0) begin : g_bad_tdata
        $fatal(1, "avl_axi_stream_fifo: TDATA_WIDTH must be a positive multiple of 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "avl_axi_stream_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic [PW-1:0] pkt_cnt, pkt_cnt_nx;
    logic          forced, forced_nx;
    logic          empty, full, empty_nx, full_nx;
    logic          push, pop, fwd, valid_nx;
    logic [AW-1:0] wr_idx, rd_idx_nx;
    logic [CW-1:0] core_mem [DEPTH];
    logic [CW-1:0] core_in, core_head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A source that ignores s_tready is gated by fullness alone; that is
    // where a beat can be lost and overflow gets raised.
    assign push = s_tvalid && ((Tready_Signal != 0) ? s_tready : !full);
    assign pop  = m_tvalid && m_tready;

    assign wr_ptr_nx = wr_ptr + PW'(push);
    assign rd_ptr_nx = rd_ptr + PW'(pop);
    assign empty_nx  = (wr_ptr_nx == rd_ptr_nx);
    assign full_nx   = (wr_ptr_nx[AW-1:0] == rd_ptr_nx[AW-1:0]) &&
                       (wr_ptr_nx[AW] != rd_ptr_nx[AW]);
    assign wr_idx    = wr_ptr[AW-1:0];
    assign rd_idx_nx = rd_ptr_nx[AW-1:0];
    assign level     = wr_ptr - rd_ptr;

    // The next head is the beat being written when the buffer drains to it.
    assign fwd       = push && (wr_ptr == rd_ptr_nx);
    assign core_in   = {s_tlast, s_tkeep, s_tstrb, s_tdata};
    assign core_head = fwd ? core_in : core_mem[rd_idx_nx];

    // Packet accounting and release decision for the beat presented next.
    always_comb begin
        pkt_cnt_nx = pkt_cnt;
        forced_nx  = 1'b0;
        valid_nx   = !empty_nx;
        if (PACKET_MODE != 0) begin
            if ((push && s_tlast) && !(pop && m_tlast))
                pkt_cnt_nx = pkt_cnt + PW'(1);
            else if (!(push && s_tlast) && (pop && m_tlast))
                pkt_cnt_nx = pkt_cnt - PW'(1);
            // A full buffer holding no complete packet would deadlock, so it
            // releases cut-through until the packet at the head ends.
            forced_nx = full_nx || (forced && !(pop && m_tlast));
            valid_nx  = !empty_nx && ((pkt_cnt_nx != '0) || forced_nx);
        end
    end

    // Payload storage, written only on accepted beats and never cleared.
    always_ff @(posedge aclk) begin
        if (push) core_mem[wr_idx] <= core_in;
    end

    // Pointers, packet state, handshake flags and the registered head beat.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            forced   <= 1'b0;
            m_tvalid <= 1'b0;
            s_tready <= 1'b0;
            overflow <= 1'b0;
            {m_tlast, m_tkeep, m_tstrb, m_tdata} <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nx;
            rd_ptr   <= rd_ptr_nx;
            pkt_cnt  <= pkt_cnt_nx;
            forced   <= forced_nx;
            m_tvalid <= valid_nx;
            // level_next < DEPTH is exactly "not full after this edge".
            s_tready <= !full_nx;
            if ((Tready_Signal == 0) && s_tvalid && full) overflow <= 1'b1;
            if (!empty_nx) {m_tlast, m_tkeep, m_tstrb, m_tdata} <= core_head;
        end
    end

    if (TID_WIDTH > 0) begin : g_tid
        logic [IW-1:0] tid_mem [DEPTH];
        // tid storage follows the core payload path.
        always_ff @(posedge aclk) begin
            if (push) tid_mem[wr_idx] <= s_tid;
        end
        // Registered tid of the next head.
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) m_tid <= '0;
            else if (!empty_nx) m_tid <= fwd ? s_tid : tid_mem[rd_idx_nx];
        end
    end else begin : g_no_tid
        wire unused_tid = ^s_tid;
        assign m_tid = '0;
    end

    if (TDEST_WIDTH > 0) begin : g_tdest
        logic [DW-1:0] tdest_mem [DEPTH];
        // tdest storage follows the core payload path.
        always_ff @(posedge aclk) begin
            if (push) tdest_mem[wr_idx] <= s_tdest;
        end
        // Registered tdest of the next head.
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) m_tdest <= '0;
            else if (!empty_nx) m_tdest <= fwd ? s_tdest : tdest_mem[rd_idx_nx];
        end
    end else begin : g_no_tdest
        wire unused_tdest = ^s_tdest;
        assign m_tdest = '0;
    end

    if (TUSER_WIDTH > 0) begin : g_tuser
        logic [UW-1:0] tuser_mem [DEPTH];
        // tuser storage follows the core payload path.
        always_ff @(posedge aclk) begin
            if (push) tuser_mem[wr_idx] <= s_tuser;
        end
        // Registered tuser of the next head.
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) m_tuser <= '0;
            else if (!empty_nx) m_tuser <= fwd ? s_tuser : tuser_mem[rd_idx_nx];
        end
    end else begin : g_no_tuser
        wire unused_tuser = ^s_tuser;
        assign m_tuser = '0;
    end

    if (VERSION >= 5) begin : g_wakeup
        // Wakeup reflects the source request or any buffered beat, one cycle late.
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) m_twakeup <= 1'b0;
            else        m_twakeup <= s_twakeup || !empty;
        end
    end else begin : g_no_wakeup
        wire unused_twakeup = s_twakeup;
        assign m_twakeup = 1'b0;
    end

endmodule

// File: tb/tb_avl_axi_stream_fifo.sv
// Directed bench: four buffer configurations share one stimulus bus; each
// scenario resets everything and checks the instance it targets.
module tb_avl_axi_stream_fifo;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_tvalid, s_tlast, s_twakeup, m_tready;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb, s_tkeep, s_tid;
    logic [2:0]  s_tdest;
    logic [1:0]  s_tuser;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    // u_a: DEPTH=4, stream mode, VERSION 5, no sidebands
    logic        s_tready_a, m_tvalid_a, m_tlast_a, m_twakeup_a, overflow_a;
    logic [31:0] m_tdata_a;
    logic [3:0]  m_tstrb_a, m_tkeep_a;
    logic        m_tid_a, m_tdest_a, m_tuser_a;
    logic [2:0]  level_a;

    // u_b: DEPTH=8, packet mode, tid/tdest/tuser present
    logic        s_tready_b, m_tvalid_b, m_tlast_b, m_twakeup_b, overflow_b;
    logic [31:0] m_tdata_b;
    logic [3:0]  m_tstrb_b, m_tkeep_b, m_tid_b;
    logic [2:0]  m_tdest_b;
    logic [1:0]  m_tuser_b;
    logic [3:0]  level_b;

    // u_c: DEPTH=4, packet mode
    logic        s_tready_c, m_tvalid_c, m_tlast_c, m_twakeup_c, overflow_c;
    logic [31:0] m_tdata_c;
    logic [3:0]  m_tstrb_c, m_tkeep_c;
    logic        m_tid_c, m_tdest_c, m_tuser_c;
    logic [2:0]  level_c;

    // u_d: DEPTH=2, source without tready
    logic        s_tready_d, m_tvalid_d, m_tlast_d, m_twakeup_d, overflow_d;
    logic [31:0] m_tdata_d;
    logic [3:0]  m_tstrb_d, m_tkeep_d;
    logic        m_tid_d, m_tdest_d, m_tuser_d;
    logic [1:0]  level_d;

    avl_axi_stream_fifo #(.VERSION(5), .TDATA_WIDTH(32), .DEPTH(4), .PACKET_MODE(0), .Tready_Signal(1)) u_a (
        .aclk(aclk), .areset(areset), .s_tvalid(s_tvalid), .s_tready(s_tready_a), .s_tdata(s_tdata),
        .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid[0:0]), .s_tdest(s_tdest[0:0]),
        .s_tuser(s_tuser[0:0]), .s_twakeup(s_twakeup), .m_tvalid(m_tvalid_a), .m_tready(m_tready),
        .m_tdata(m_tdata_a), .m_tstrb(m_tstrb_a), .m_tkeep(m_tkeep_a), .m_tlast(m_tlast_a), .m_tid(m_tid_a),
        .m_tdest(m_tdest_a), .m_tuser(m_tuser_a), .m_twakeup(m_twakeup_a), .level(level_a), .overflow(overflow_a));

    avl_axi_stream_fifo #(.VERSION(4), .TDATA_WIDTH(32), .TID_WIDTH(4), .TDEST_WIDTH(3), .TUSER_WIDTH(2),
                          .DEPTH(8), .PACKET_MODE(1), .Tready_Signal(1)) u_b (
        .aclk(aclk), .areset(areset), .s_tvalid(s_tvalid), .s_tready(s_tready_b), .s_tdata(s_tdata),
        .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest),
        .s_tuser(s_tuser), .s_twakeup(s_twakeup), .m_tvalid(m_tvalid_b), .m_tready(m_tready),
        .m_tdata(m_tdata_b), .m_tstrb(m_tstrb_b), .m_tkeep(m_tkeep_b), .m_tlast(m_tlast_b), .m_tid(m_tid_b),
        .m_tdest(m_tdest_b), .m_tuser(m_tuser_b), .m_twakeup(m_twakeup_b), .level(level_b), .overflow(overflow_b));

    avl_axi_stream_fifo #(.VERSION(4), .TDATA_WIDTH(32), .DEPTH(4), .PACKET_MODE(1), .Tready_Signal(1)) u_c (
        .aclk(aclk), .areset(areset), .s_tvalid(s_tvalid), .s_tready(s_tready_c), .s_tdata(s_tdata),
        .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid[0:0]), .s_tdest(s_tdest[0:0]),
        .s_tuser(s_tuser[0:0]), .s_twakeup(s_twakeup), .m_tvalid(m_tvalid_c), .m_tready(m_tready),
        .m_tdata(m_tdata_c), .m_tstrb(m_tstrb_c), .m_tkeep(m_tkeep_c), .m_tlast(m_tlast_c), .m_tid(m_tid_c),
        .m_tdest(m_tdest_c), .m_tuser(m_tuser_c), .m_twakeup(m_twakeup_c), .level(level_c), .overflow(overflow_c));

    avl_axi_stream_fifo #(.VERSION(4), .TDATA_WIDTH(32), .DEPTH(2), .PACKET_MODE(0), .Tready_Signal(0)) u_d (
        .aclk(aclk), .areset(areset), .s_tvalid(s_tvalid), .s_tready(s_tready_d), .s_tdata(s_tdata),
        .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid[0:0]), .s_tdest(s_tdest[0:0]),
        .s_tuser(s_tuser[0:0]), .s_twakeup(s_twakeup), .m_tvalid(m_tvalid_d), .m_tready(m_tready),
        .m_tdata(m_tdata_d), .m_tstrb(m_tstrb_d), .m_tkeep(m_tkeep_d), .m_tlast(m_tlast_d), .m_tid(m_tid_d),
        .m_tdest(m_tdest_d), .m_tuser(m_tuser_d), .m_twakeup(m_twakeup_d), .level(level_d), .overflow(overflow_d));

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        s_tvalid = 1'b0; s_tlast = 1'b0; s_twakeup = 1'b0; m_tready = 1'b0;
        s_tdata = '0; s_tstrb = 4'hF; s_tkeep = 4'hF;
        s_tid = '0; s_tdest = '0; s_tuser = '0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        idle_inputs();
        tick();
        tick();
        areset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        idle_inputs();
        tick();
        checks++;
        if (level_a !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level_a); end
        checks++;
        if (m_tvalid_a !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b expected 0", m_tvalid_a); end
        checks++;
        if (s_tready_a !== 1'b0) begin errors++; $display("FAIL reset_s_tready: got %b expected 0", s_tready_a); end
        checks++;
        if (overflow_d !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow_d); end
        checks++;
        if (m_twakeup_a !== 1'b0) begin errors++; $display("FAIL reset_twakeup: got %b expected 0", m_twakeup_a); end
        checks++;
        if ({m_tdata_b, m_tid_b, m_tdest_b, m_tuser_b, m_tlast_b} !== 42'd0) begin
            errors++; $display("FAIL reset_payload: got %h expected 0", {m_tdata_b, m_tid_b, m_tdest_b, m_tuser_b, m_tlast_b});
        end
        areset = 1'b0;
        checks++;
        if (s_tready_a !== 1'b0) begin errors++; $display("FAIL release_s_tready_early: got %b expected 0", s_tready_a); end
        tick();
        checks++;
        if (s_tready_a !== 1'b1) begin errors++; $display("FAIL release_s_tready: got %b expected 1", s_tready_a); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        s_tid = 4'hF; s_tdest = 3'h7; s_tuser = 2'h3;
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'hA0 + 32'(i);
            tick();
        end
        checks++;
        if (level_a !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d expected 4", level_a); end
        checks++;
        if (s_tready_a !== 1'b0) begin errors++; $display("FAIL fill_s_tready: got %b expected 0", s_tready_a); end
        checks++;
        if ({m_tid_a, m_tdest_a, m_tuser_a} !== 3'b000) begin
            errors++; $display("FAIL absent_sideband: got %b expected 000", {m_tid_a, m_tdest_a, m_tuser_a});
        end
        checks++;
        if (m_twakeup_a !== 1'b1) begin errors++; $display("FAIL wakeup_busy: got %b expected 1", m_twakeup_a); end
        s_tdata = 32'hEE;
        tick();
        s_tvalid = 1'b0;
        checks++;
        if ({level_a, m_tvalid_a, overflow_a} !== {3'd4, 1'b1, 1'b0} || m_tdata_a !== 32'hA0) begin
            errors++; $display("FAIL full_hold: got level=%0d valid=%b ovf=%b data=%h expected level=4 valid=1 ovf=0 data=a0",
                               level_a, m_tvalid_a, overflow_a, m_tdata_a);
        end
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_tvalid_a !== 1'b1 || m_tdata_a !== 32'hA0 + 32'(i)) begin
                errors++; $display("FAIL drain_%0d: got valid=%b data=%h expected valid=1 data=%h",
                                   i, m_tvalid_a, m_tdata_a, 32'hA0 + 32'(i));
            end
            tick();
        end
        checks++;
        if (m_tvalid_a !== 1'b0 || level_a !== 3'd0) begin
            errors++; $display("FAIL drain_empty: got valid=%b level=%0d expected 0 0", m_tvalid_a, level_a);
        end
        tick();
        checks++;
        if (m_twakeup_a !== 1'b0) begin errors++; $display("FAIL wakeup_idle: got %b expected 0", m_twakeup_a); end
        s_twakeup = 1'b1;
        tick();
        s_twakeup = 1'b0;
        checks++;
        if (m_twakeup_a !== 1'b1) begin errors++; $display("FAIL wakeup_req: got %b expected 1", m_twakeup_a); end
    endtask

    task automatic test_back_to_back();
        int   sent, got;
        logic acc, exp_pop;
        do_reset();
        m_tready = 1'b1;
        sent = 0;
        got  = 0;
        for (int c = 0; c < 14; c++) begin
            s_tvalid = (sent < 12);
            s_tdata  = 32'hB0 + 32'(sent);
            acc      = s_tvalid && s_tready_a;
            exp_pop  = (c >= 1 && c <= 12);
            checks++;
            if (m_tvalid_a !== exp_pop) begin
                errors++; $display("FAIL b2b_valid cycle %0d: got %b expected %b", c, m_tvalid_a, exp_pop);
            end
            if (m_tvalid_a === 1'b1) begin
                checks++;
                if (m_tdata_a !== 32'hB0 + 32'(got)) begin
                    errors++; $display("FAIL b2b_data beat %0d: got %h expected %h", got, m_tdata_a, 32'hB0 + 32'(got));
                end
                got++;
            end
            tick();
            if (acc) sent++;
            checks++;
            if (level_a !== ((c < 12) ? 3'd1 : 3'd0)) begin
                errors++; $display("FAIL b2b_level cycle %0d: got %0d expected %0d", c, level_a, (c < 12) ? 1 : 0);
            end
        end
        s_tvalid = 1'b0;
        checks++;
        if (got != 12) begin errors++; $display("FAIL b2b_count: got %0d expected 12", got); end
    endtask

    task automatic test_packet();
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'hC0 + 32'(i);
            s_tlast  = (i == 2);
            tick();
            checks++;
            if (m_tvalid_b !== (i == 2)) begin
                errors++; $display("FAIL pkt_hold beat %0d: got valid=%b expected %b", i, m_tvalid_b, (i == 2));
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_tvalid_b !== 1'b1 || m_tdata_b !== 32'hC0 + 32'(i) || m_tlast_b !== (i == 2)) begin
                errors++; $display("FAIL pkt_out beat %0d: got valid=%b data=%h last=%b expected 1 %h %b",
                                   i, m_tvalid_b, m_tdata_b, m_tlast_b, 32'hC0 + 32'(i), (i == 2));
            end
            tick();
        end
        checks++;
        if (m_tvalid_b !== 1'b0 || level_b !== 4'd0) begin
            errors++; $display("FAIL pkt_done: got valid=%b level=%0d expected 0 0", m_tvalid_b, level_b);
        end
    endtask

    task automatic test_forced_release();
        int   sent, got;
        logic acc;
        do_reset();
        m_tready = 1'b1;
        sent = 0;
        got  = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            s_tvalid = (sent < 6);
            s_tdata  = 32'hD0 + 32'(sent);
            s_tlast  = (sent == 5);
            acc      = s_tvalid && s_tready_c;
            if (m_tvalid_c === 1'b1) begin
                if (got == 0) begin
                    checks++;
                    if (level_c !== 3'd4) begin
                        errors++; $display("FAIL forced_start: got level=%0d expected 4", level_c);
                    end
                end
                checks++;
                if (m_tdata_c !== 32'hD0 + 32'(got) || m_tlast_c !== (got == 5)) begin
                    errors++; $display("FAIL forced_beat %0d: got data=%h last=%b expected %h %b",
                                       got, m_tdata_c, m_tlast_c, 32'hD0 + 32'(got), (got == 5));
                end
                got++;
            end
            tick();
            if (acc) sent++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        checks++;
        if (got != 6 || m_tvalid_c !== 1'b0 || level_c !== 3'd0) begin
            errors++; $display("FAIL forced_done: got beats=%0d valid=%b level=%0d expected 6 0 0", got, m_tvalid_c, level_c);
        end
        s_tvalid = 1'b1;
        s_tdata  = 32'hE0;
        tick();
        s_tvalid = 1'b0;
        tick();
        checks++;
        if (m_tvalid_c !== 1'b0 || level_c !== 3'd1) begin
            errors++; $display("FAIL forced_pktcnt_clear: got valid=%b level=%0d expected 0 1", m_tvalid_c, level_c);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'hF0 + 32'(i);
            tick();
            checks++;
            if (overflow_d !== (i == 2)) begin
                errors++; $display("FAIL ovf_push %0d: got %b expected %b", i, overflow_d, (i == 2));
            end
        end
        s_tvalid = 1'b0;
        checks++;
        if (level_d !== 2'd2 || s_tready_d !== 1'b0) begin
            errors++; $display("FAIL ovf_full: got level=%0d ready=%b expected 2 0", level_d, s_tready_d);
        end
        tick();
        m_tready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (m_tvalid_d !== 1'b1 || m_tdata_d !== 32'hF0 + 32'(i)) begin
                errors++; $display("FAIL ovf_drain %0d: got valid=%b data=%h expected 1 %h",
                                   i, m_tvalid_d, m_tdata_d, 32'hF0 + 32'(i));
            end
            tick();
        end
        checks++;
        if (m_tvalid_d !== 1'b0 || overflow_d !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: got valid=%b ovf=%b expected 0 1", m_tvalid_d, overflow_d);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'h60 + 32'(i);
            s_tid    = 4'hA;
            tick();
        end
        s_tvalid = 1'b0;
        checks++;
        if (level_b !== 4'd3 || m_tvalid_b !== 1'b0 || s_tready_b !== 1'b1) begin
            errors++; $display("FAIL mid_pkt_setup: got level=%0d valid=%b ready=%b expected 3 0 1", level_b, m_tvalid_b, s_tready_b);
        end
        areset = 1'b1;
        #1;
        checks++;
        if (level_b !== 4'd0 || m_tvalid_b !== 1'b0 || s_tready_b !== 1'b0) begin
            errors++; $display("FAIL async_reset: got level=%0d valid=%b ready=%b expected 0 0 0", level_b, m_tvalid_b, s_tready_b);
        end
        tick();
        areset = 1'b0;
        tick();
        s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = 32'h1234_5678;
        s_tid = 4'h5; s_tdest = 3'h6; s_tuser = 2'h2; s_tkeep = 4'h3; s_tstrb = 4'h1; s_twakeup = 1'b1;
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0; s_twakeup = 1'b0;
        checks++;
        if (m_tvalid_b !== 1'b1 || level_b !== 4'd1 || m_tdata_b !== 32'h1234_5678 || m_tlast_b !== 1'b1) begin
            errors++; $display("FAIL new_pkt_beat: got valid=%b level=%0d data=%h last=%b expected 1 1 12345678 1",
                               m_tvalid_b, level_b, m_tdata_b, m_tlast_b);
        end
        checks++;
        if ({m_tid_b, m_tdest_b, m_tuser_b, m_tkeep_b, m_tstrb_b} !== {4'h5, 3'h6, 2'h2, 4'h3, 4'h1}) begin
            errors++; $display("FAIL new_pkt_sideband: got tid=%h tdest=%h tuser=%h tkeep=%h tstrb=%h expected 5 6 2 3 1",
                               m_tid_b, m_tdest_b, m_tuser_b, m_tkeep_b, m_tstrb_b);
        end
        checks++;
        if (m_twakeup_b !== 1'b0) begin errors++; $display("FAIL v4_wakeup: got %b expected 0", m_twakeup_b); end
        m_tready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (m_tvalid_b !== 1'b0 || level_b !== 4'd0) begin
            errors++; $display("FAIL new_pkt_alone: got valid=%b level=%0d expected 0 0", m_tvalid_b, level_b);
        end
    endtask

    initial begin
        areset = 1'b1;
        idle_inputs();
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_packet();
        test_forced_release();
        test_overflow();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "time limit");
    end

endmodule
